// File: rtl/tinyqv_bus_pkg.sv
// Shared encodings and helpers for the tinyQV peripheral data bus.
// Size codes follow the CPU's active-low size fields; 11 means no transfer.
package tinyqv_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_NONE = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    RESP   = 2'b10,
    ERR    = 2'b11
  } bus_state_e;

  // Zero-extends read data to the requested size; a write (SZ_NONE read) returns 0.
  function automatic logic [31:0] size_mask(input logic [31:0] data, input logic [1:0] size_n);
    case (size_n)
      SZ_BYTE: return {24'h0, data[7:0]};
      SZ_HALF: return {16'h0, data[15:0]};
      SZ_WORD: return data;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/tinyqv_bus_timeout.sv
// Watchdog counter for a peripheral access: counts enabled cycles and flags the
// final permitted cycle. A TIMEOUT_CYCLES of 0 removes the watchdog entirely.
module tinyqv_bus_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear_i,
  input  logic en_i,
  output logic term_o
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    assign term_o = 1'b0;
  end else begin : g_on
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
      if (!rstn || clear_i) begin
        cnt_q <= '0;
      end else if (en_i) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign term_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

endmodule

// File: rtl/tinyqv_periph_bus.sv
// Peripheral-side data bus for tinyQV: decodes a CPU data access to one channel,
// waits for that channel's ready under a watchdog, and returns data or a bus error.
module tinyqv_periph_bus
  import tinyqv_bus_pkg::*;
#(
  parameter int unsigned NUM_PERIPH     = 4,
  parameter int unsigned SEL_LSB        = 6,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [27:0]              data_addr,
  input  logic [1:0]               data_write_n,
  input  logic [1:0]               data_read_n,
  input  logic                     data_read_complete,
  input  logic [31:0]              data_out,
  output logic                     data_ready,
  output logic [31:0]              data_in,
  output logic [NUM_PERIPH-1:0]    periph_sel,
  output logic [27:0]              periph_addr,
  output logic [1:0]               periph_write_n,
  output logic [1:0]               periph_read_n,
  output logic [31:0]              periph_data_out,
  output logic [NUM_PERIPH-1:0]    periph_read_complete,
  input  logic [NUM_PERIPH-1:0]    periph_ready,
  input  logic [32*NUM_PERIPH-1:0] periph_data_in,
  input  logic                     err_clear,
  output logic                     err_valid,
  output logic                     err_timeout,
  output logic [27:0]              err_addr
);

  localparam int unsigned SEL_W = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
  localparam logic [NUM_PERIPH-1:0] CH_ONE = NUM_PERIPH'(1);

  bus_state_e            state_q;
  logic [SEL_W-1:0]      ch_q, last_ch_q;
  logic [27:0]           addr_q, err_addr_q;
  logic [31:0]           wdata_q, data_in_q;
  logic [1:0]            write_n_q, read_n_q, periph_write_n_q, periph_read_n_q;
  logic [NUM_PERIPH-1:0] periph_sel_q, periph_rc_q;
  logic                  data_ready_q, holdoff_q, to_cause_q, last_valid_q;
  logic                  err_valid_q, err_timeout_q;

  logic             req, accept, mapped_d, ch_ready, to_term;
  logic [SEL_W-1:0] ch_d;
  logic [1:0]       read_n_d;
  logic [31:0]      ch_rdata;

  assign req      = (data_write_n != SZ_NONE) || (data_read_n != SZ_NONE);
  assign accept   = (state_q == IDLE) && req && !holdoff_q && !data_ready_q;
  assign ch_d     = data_addr[SEL_LSB +: SEL_W];
  assign mapped_d = 32'(ch_d) < NUM_PERIPH;
  // A simultaneous read request is dropped when a write is present.
  assign read_n_d = (data_write_n != SZ_NONE) ? SZ_NONE : data_read_n;

  // NOTE: defaults first so no path leaves ch_ready/ch_rdata unassigned (no latch).
  always_comb begin
    ch_ready = 1'b0;
    ch_rdata = '0;
    for (int k = 0; k < NUM_PERIPH; k++) begin
      if (ch_q == SEL_W'(k)) begin
        ch_ready = periph_ready[k];
        ch_rdata = periph_data_in[32*k +: 32];
      end
    end
  end

  tinyqv_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .clear_i(state_q != ACTIVE),
    .en_i   (state_q == ACTIVE),
    .term_o (to_term)
  );

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; latched datapath is cleared too so outputs are deterministic after reset.
    if (!rstn) begin
      state_q          <= IDLE;
      ch_q             <= '0;
      last_ch_q        <= '0;
      last_valid_q     <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      write_n_q        <= SZ_NONE;
      read_n_q         <= SZ_NONE;
      periph_sel_q     <= '0;
      periph_write_n_q <= SZ_NONE;
      periph_read_n_q  <= SZ_NONE;
      periph_rc_q      <= '0;
      data_ready_q     <= 1'b0;
      data_in_q        <= '0;
      holdoff_q        <= 1'b0;
      to_cause_q       <= 1'b0;
      err_valid_q      <= 1'b0;
      err_timeout_q    <= 1'b0;
      err_addr_q       <= '0;
    end else begin
      data_ready_q <= 1'b0;
      holdoff_q    <= data_ready_q;
      periph_rc_q  <= (data_read_complete && last_valid_q) ? (CH_ONE << last_ch_q) : '0;
      if (err_clear) begin
        err_valid_q   <= 1'b0;
        err_timeout_q <= 1'b0;
        err_addr_q    <= '0;
      end

      case (state_q)
        IDLE: if (accept) begin
          addr_q     <= data_addr;
          wdata_q    <= data_out;
          ch_q       <= ch_d;
          write_n_q  <= data_write_n;
          read_n_q   <= read_n_d;
          to_cause_q <= 1'b0;
          if (mapped_d) begin
            state_q          <= ACTIVE;
            periph_sel_q     <= CH_ONE << ch_d;
            periph_write_n_q <= data_write_n;
            periph_read_n_q  <= read_n_d;
          end else begin
            state_q <= ERR;
          end
        end
        ACTIVE: if (ch_ready || to_term) begin
          periph_sel_q     <= '0;
          periph_write_n_q <= SZ_NONE;
          periph_read_n_q  <= SZ_NONE;
          if (ch_ready) begin
            state_q      <= RESP;
            data_ready_q <= 1'b1;
            data_in_q    <= size_mask(ch_rdata, read_n_q);
            if (read_n_q != SZ_NONE) begin
              last_ch_q    <= ch_q;
              last_valid_q <= 1'b1;
            end
          end else begin
            state_q    <= ERR;
            to_cause_q <= 1'b1;
          end
        end
        RESP: state_q <= IDLE;
        ERR: begin
          state_q      <= IDLE;
          data_ready_q <= 1'b1;
          data_in_q    <= (read_n_q != SZ_NONE) ? ERR_DATA : 32'h0;
          // The first error is kept; a clear in this same cycle lets the new one in.
          if (!err_valid_q || err_clear) begin
            err_valid_q   <= 1'b1;
            err_timeout_q <= to_cause_q;
            err_addr_q    <= addr_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_ready           = data_ready_q;
  assign data_in              = data_in_q;
  assign periph_sel           = periph_sel_q;
  assign periph_addr          = addr_q;
  assign periph_write_n       = periph_write_n_q;
  assign periph_read_n        = periph_read_n_q;
  assign periph_data_out      = wdata_q;
  assign periph_read_complete = periph_rc_q;
  assign err_valid            = err_valid_q;
  assign err_timeout          = err_timeout_q;
  assign err_addr             = err_addr_q;

endmodule

// File: tb/tb_tinyqv_periph_bus.sv
// Directed scoreboard bench for tinyqv_periph_bus: five channels (index 5..7 unmapped)
// and an 8-cycle watchdog. Inputs change and outputs are sampled on the falling edge.
module tb_tinyqv_periph_bus;
  import tinyqv_bus_pkg::*;

  localparam int NP = 5;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic [27:0]     data_addr;
  logic [1:0]      data_write_n, data_read_n;
  logic            data_read_complete;
  logic [31:0]     data_out;
  logic            data_ready;
  logic [31:0]     data_in;
  logic [NP-1:0]   periph_sel;
  logic [27:0]     periph_addr;
  logic [1:0]      periph_write_n, periph_read_n;
  logic [31:0]     periph_data_out;
  logic [NP-1:0]   periph_read_complete;
  logic [NP-1:0]   periph_ready;
  logic [32*NP-1:0] periph_data_in;
  logic            err_clear;
  logic            err_valid, err_timeout;
  logic [27:0]     err_addr;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   tick_no  = 0;

  always #5 clk = ~clk;

  tinyqv_periph_bus #(
    .NUM_PERIPH    (NP),
    .SEL_LSB       (6),
    .TIMEOUT_CYCLES(TO),
    .ERR_DATA      (32'hFFFF_FFFF)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .data_addr           (data_addr),
    .data_write_n        (data_write_n),
    .data_read_n         (data_read_n),
    .data_read_complete  (data_read_complete),
    .data_out            (data_out),
    .data_ready          (data_ready),
    .data_in             (data_in),
    .periph_sel          (periph_sel),
    .periph_addr         (periph_addr),
    .periph_write_n      (periph_write_n),
    .periph_read_n       (periph_read_n),
    .periph_data_out     (periph_data_out),
    .periph_read_complete(periph_read_complete),
    .periph_ready        (periph_ready),
    .periph_data_in      (periph_data_in),
    .err_clear           (err_clear),
    .err_valid           (err_valid),
    .err_timeout         (err_timeout),
    .err_addr            (err_addr)
  );

  task automatic tick();
    @(negedge clk);
    tick_no++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a CPU request and record the response it must produce, lat ticks from now.
  task automatic issue(input logic [27:0] addr, input logic [1:0] wn, input logic [1:0] rn,
                       input logic [31:0] wdata, input logic [31:0] exp_data, input int lat);
    exp_t e;
    data_addr    = addr;
    data_write_n = wn;
    data_read_n  = rn;
    data_out     = wdata;
    e.data = exp_data;
    e.due  = tick_no + lat;
    sb.push_back(e);
  endtask

  task automatic set_ready(input int ch, input logic [31:0] rdata);
    periph_ready                 = '0;
    periph_ready[ch]             = 1'b1;
    periph_data_in[32*ch +: 32]  = rdata;
  endtask

  task automatic expect_resp(input string tag, input int budget);
    exp_t e;
    bit   seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = (data_ready === 1'b1);
    end
    check({tag, "_ready"}, 32'(data_ready), 32'd1);
    e = sb.pop_front();
    if (seen) begin
      check({tag, "_data"}, data_in, e.data);
      check({tag, "_cycle"}, 32'(tick_no), 32'(e.due));
      check({tag, "_sel_idle"}, 32'(periph_sel), 32'h0);
    end
  endtask

  // CPU drops its request after data_ready; waits out the holdoff cycle.
  task automatic release_req(input string tag);
    data_write_n = SZ_NONE;
    data_read_n  = SZ_NONE;
    periph_ready = '0;
    tick();
    check({tag, "_pulse_end"}, 32'(data_ready), 32'h0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; data_addr = '0; data_write_n = SZ_NONE; data_read_n = SZ_NONE;
    data_read_complete = 1'b0; data_out = '0; periph_ready = '0; periph_data_in = '0;
    err_clear = 1'b0;
    tick(); tick();
    check("rst_sel", 32'(periph_sel), 32'h0);
    check("rst_wn", 32'(periph_write_n), 32'h3);
    check("rst_rn", 32'(periph_read_n), 32'h3);
    check("rst_ready", 32'(data_ready), 32'h0);
    check("rst_data_in", data_in, 32'h0);
    check("rst_err_valid", 32'(err_valid), 32'h0);
    check("rst_rc", 32'(periph_read_complete), 32'h0);

    // No completed read yet: read-complete must not pulse any channel.
    rstn = 1'b1;
    data_read_complete = 1'b1;
    tick();
    data_read_complete = 1'b0;
    check("rc_suppressed", 32'(periph_read_complete), 32'h0);
    tick();

    // 32-bit read on ch1, ready 3 cycles after select, then request held through holdoff.
    issue(28'h800_0040, SZ_NONE, SZ_WORD, 32'h0, 32'h1234_5678, 5);
    tick();
    check("t1_sel", 32'(periph_sel), 32'h02);
    check("t1_rn", 32'(periph_read_n), 32'(SZ_WORD));
    check("t1_addr", 32'(periph_addr), 32'h800_0040);
    periph_ready[0] = 1'b1;
    periph_data_in[31:0] = 32'hDEAD_0000;
    tick(); tick();
    check("t1_unsel_ignored", 32'(data_ready), 32'h0);
    check("t1_sel_hold", 32'(periph_sel), 32'h02);
    tick();
    set_ready(1, 32'h1234_5678);
    expect_resp("t1_rd32", 4);
    periph_ready = '0;
    tick();
    check("t1_one_pulse", 32'(data_ready), 32'h0);
    tick();
    check("t1_holdoff_sel", 32'(periph_sel), 32'h0);
    release_req("t1");

    // 8-bit read on ch0.
    issue(28'h800_0000, SZ_NONE, SZ_BYTE, 32'h0, 32'h0000_00DD, 2);
    tick();
    set_ready(0, 32'hAABB_CCDD);
    expect_resp("t2_rd8", 6);
    release_req("t2");

    // 16-bit write on ch2 with a read requested alongside: the write wins.
    issue(28'h800_0080, SZ_HALF, SZ_WORD, 32'h0000_BEEF, 32'h0, 2);
    tick();
    check("t3_sel", 32'(periph_sel), 32'h04);
    check("t3_wn", 32'(periph_write_n), 32'(SZ_HALF));
    check("t3_rn", 32'(periph_read_n), 32'(SZ_NONE));
    check("t3_wdata", periph_data_out, 32'h0000_BEEF);
    set_ready(2, 32'h5555_AAAA);
    expect_resp("t3_wr16", 6);
    release_req("t3");

    // 16-bit read on the highest mapped channel.
    issue(28'h800_0100, SZ_NONE, SZ_HALF, 32'h0, 32'h0000_F00D, 2);
    tick();
    check("t4_sel", 32'(periph_sel), 32'h10);
    set_ready(4, 32'hCAFE_F00D);
    expect_resp("t4_rd16", 6);
    release_req("t4");

    // Read on ch3, then read-complete pulses ch3 for exactly one cycle.
    issue(28'h800_00C0, SZ_NONE, SZ_WORD, 32'h0, 32'h3333_0003, 2);
    tick();
    set_ready(3, 32'h3333_0003);
    expect_resp("t5_rd32", 6);
    release_req("t5");
    data_read_complete = 1'b1;
    tick();
    data_read_complete = 1'b0;
    check("t5_rc_pulse", 32'(periph_read_complete), 32'h08);
    tick();
    check("t5_rc_end", 32'(periph_read_complete), 32'h0);

    // Unmapped channel 5.
    issue(28'h800_0140, SZ_NONE, SZ_WORD, 32'h0, 32'hFFFF_FFFF, 2);
    tick();
    check("t6_no_sel", 32'(periph_sel), 32'h0);
    expect_resp("t6_unmapped", 6);
    check("t6_err_valid", 32'(err_valid), 32'h1);
    check("t6_err_timeout", 32'(err_timeout), 32'h0);
    check("t6_err_addr", 32'(err_addr), 32'h800_0140);
    release_req("t6");
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("t6_cleared", 32'(err_valid), 32'h0);

    // Timeout on ch3: eight ACTIVE cycles, then the error response.
    issue(28'h800_00C0, SZ_NONE, SZ_WORD, 32'h0, 32'hFFFF_FFFF, TO + 2);
    repeat (TO) tick();
    check("t7_last_active", 32'(periph_sel), 32'h08);
    expect_resp("t7_timeout", 6);
    check("t7_err_valid", 32'(err_valid), 32'h1);
    check("t7_err_timeout", 32'(err_timeout), 32'h1);
    check("t7_err_addr", 32'(err_addr), 32'h800_00C0);
    release_req("t7");

    // Second timeout (a write, so data_in is 0) leaves the first record alone.
    issue(28'h800_0080, SZ_WORD, SZ_NONE, 32'h1, 32'h0, TO + 2);
    expect_resp("t8_timeout_wr", TO + 6);
    check("t8_err_addr_kept", 32'(err_addr), 32'h800_00C0);
    check("t8_err_timeout_kept", 32'(err_timeout), 32'h1);
    release_req("t8");

    // Clear coinciding with a new unmapped error: the new error is recorded.
    issue(28'h800_0180, SZ_NONE, SZ_WORD, 32'h0, 32'hFFFF_FFFF, 2);
    tick();
    err_clear = 1'b1;
    expect_resp("t9_unmapped", 6);
    err_clear = 1'b0;
    check("t9_err_valid", 32'(err_valid), 32'h1);
    check("t9_err_addr", 32'(err_addr), 32'h800_0180);
    check("t9_err_timeout", 32'(err_timeout), 32'h0);
    release_req("t9");

    // Reset while ACTIVE, then a normal ch0 read.
    data_addr = 28'h800_0040; data_read_n = SZ_WORD;
    tick();
    check("t10_active", 32'(periph_sel), 32'h02);
    rstn = 1'b0;
    set_ready(1, 32'h7777_7777);
    tick();
    check("t10_rst_sel", 32'(periph_sel), 32'h0);
    check("t10_rst_rn", 32'(periph_read_n), 32'h3);
    check("t10_rst_wn", 32'(periph_write_n), 32'h3);
    check("t10_rst_ready", 32'(data_ready), 32'h0);
    check("t10_rst_err", 32'(err_valid), 32'h0);
    rstn = 1'b1;
    data_read_n = SZ_NONE;
    periph_ready = '0;
    tick();
    check("t10_no_resp", 32'(data_ready), 32'h0);
    issue(28'h800_0000, SZ_NONE, SZ_WORD, 32'h0, 32'h0BAD_F00D, 2);
    tick();
    set_ready(0, 32'h0BAD_F00D);
    expect_resp("t10_rd32", 6);
    release_req("t10");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
